ls_mem_port_sched: RTL

- Schedules the single cache/memory port between the load queue (read requests) and the store queue (committed-store drain).
- Sits between lq/sq and mem_sys, in place of direct queue-to-cache wiring.
- Loads have default priority. Stores win when the store queue is full or a store has waited STARVE_MAX cycles.
- Handles branch-mispredict flush by squashing the in-flight load response. Committed stores are never squashed.

---
 rtl/ls_mem_port_sched_pkg.sv | 16 +
 rtl/ls_mem_port_sched_if.sv | 22 ++
 rtl/ls_mem_port_sched_starve_ctr.sv | 26 ++
 rtl/ls_mem_port_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ls_mem_port_sched_pkg.sv
// rtl/ls_mem_port_sched_pkg.sv - shared FSM encoding and default widths for the load/store port scheduler
package ls_pkg;

    localparam int unsigned LS_ADDR_W     = 16;
    localparam int unsigned LS_DATA_W     = 16;
    localparam int unsigned LS_INDX_W     = 6;
    localparam int unsigned LS_PHY_W      = 6;
    localparam int unsigned LS_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/ls_mem_port_sched_if.sv
// rtl/ls_mem_port_sched_if.sv - memory-side request/response bus between the scheduler and mem_sys
interface ls_mem_port_sched_if #(
    parameter int unsigned ADDR_W = ls_pkg::LS_ADDR_W,
    parameter int unsigned DATA_W = ls_pkg::LS_DATA_W
);
    logic              mem_rd;
    logic              mem_wrt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_vld;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd, mem_wrt, mem_addr, mem_wdata,
        input  mem_vld, mem_rdata
    );

    modport slave (
        input  mem_rd, mem_wrt, mem_addr, mem_wdata,
        output mem_vld, mem_rdata
    );
endinterface

// File: rtl/ls_mem_port_sched_starve_ctr.sv
// rtl/ls_mem_port_sched_starve_ctr.sv - store starvation counter; raises st_pri when the store queue must win
module ls_starve_ctr #(
    parameter int unsigned STARVE_MAX = ls_pkg::LS_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_st_req,
    input  logic i_st_gnt,
    input  logic i_sq_full,
    output logic o_st_pri
);
    logic [7:0] r_cnt;

    // Counts only uninterrupted waiting; any gap in st_req restarts the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_st_req || i_st_gnt) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_st_pri = i_sq_full | (r_cnt >= 8'(STARVE_MAX));
endmodule

// File: rtl/ls_mem_port_sched.sv
// rtl/ls_mem_port_sched.sv - arbitrates the single memory port between load and store queues
// Optional perf counters (loads, stores, forced store grants) under LSPS_PERF_CNT_EN.
module ls_mem_port_sched
    import ls_pkg::*;
#(
    parameter int unsigned ADDR_W     = LS_ADDR_W,
    parameter int unsigned DATA_W     = LS_DATA_W,
    parameter int unsigned INDX_W     = LS_INDX_W,
    parameter int unsigned PHY_W      = LS_PHY_W,
    parameter int unsigned STARVE_MAX = LS_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flsh,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [INDX_W-1:0] i_ld_indx,
    input  logic [PHY_W-1:0]  i_ld_phy,
    output logic              o_ld_gnt,
    input  logic              i_st_req,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [DATA_W-1:0] i_st_data,
    input  logic              i_sq_full,
    output logic              o_st_gnt,
    ls_mem_port_sched_if.master m_mem,
    output logic              o_vld_ld,
    output logic              o_reg_wrt_ld,
    output logic [DATA_W-1:0] o_data_ld,
    output logic [INDX_W-1:0] o_indx_ld,
    output logic [PHY_W-1:0]  o_phy_addr_ld,
    output logic              o_str_iss,
    output logic              o_busy
`ifdef LSPS_PERF_CNT_EN
    ,
    output logic [15:0]       o_ld_cnt,
    output logic [15:0]       o_st_cnt,
    output logic [15:0]       o_sq_prio_cnt
`endif
);
    state_t            r_state;
    logic              r_kill;
    logic              r_cool;
    logic              r_mem_rd;
    logic              r_mem_wrt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [INDX_W-1:0] r_cap_indx;
    logic [PHY_W-1:0]  r_cap_phy;
    logic              r_vld_ld;
    logic [DATA_W-1:0] r_data_ld;
    logic [INDX_W-1:0] r_indx_ld;
    logic [PHY_W-1:0]  r_phy_ld;
    logic              r_str_iss;

    logic w_st_pri;
    logic w_can_gnt;
    logic w_st_gnt;
    logic w_ld_gnt;

    ls_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_st_req  (i_st_req),
        .i_st_gnt  (w_st_gnt),
        .i_sq_full (i_sq_full),
        .o_st_pri  (w_st_pri)
    );

    // r_cool blocks the cycle right after a completion so grants are spaced 3 cycles apart.
    assign w_can_gnt = rst_n & (r_state == IDLE) & ~r_cool;
    assign w_st_gnt  = w_can_gnt & i_st_req & (w_st_pri | ~i_ld_req | i_flsh);
    assign w_ld_gnt  = w_can_gnt & i_ld_req & ~i_flsh & ~w_st_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_cool      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wrt   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cap_indx  <= '0;
            r_cap_phy   <= '0;
            r_vld_ld    <= 1'b0;
            r_data_ld   <= '0;
            r_indx_ld   <= '0;
            r_phy_ld    <= '0;
            r_str_iss   <= 1'b0;
        end else begin
            r_vld_ld  <= 1'b0;
            r_str_iss <= 1'b0;
            r_cool    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_st_gnt) begin
                        r_state     <= ST_WAIT;
                        r_mem_wrt   <= 1'b1;
                        r_mem_addr  <= i_st_addr;
                        r_mem_wdata <= i_st_data;
                    end else if (w_ld_gnt) begin
                        r_state    <= LD_WAIT;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= i_ld_addr;
                        r_cap_indx <= i_ld_indx;
                        r_cap_phy  <= i_ld_phy;
                    end
                end
                LD_WAIT: begin
                    if (i_flsh) begin
                        r_kill <= 1'b1;
                    end
                    if (m_mem.mem_vld) begin
                        r_state  <= IDLE;
                        r_mem_rd <= 1'b0;
                        r_kill   <= 1'b0;
                        r_cool   <= 1'b1;
                        // A flush seen at any point of the wait squashes the writeback.
                        if (!(r_kill || i_flsh)) begin
                            r_vld_ld  <= 1'b1;
                            r_data_ld <= m_mem.mem_rdata;
                            r_indx_ld <= r_cap_indx;
                            r_phy_ld  <= r_cap_phy;
                        end
                    end
                end
                ST_WAIT: begin
                    if (m_mem.mem_vld) begin
                        r_state   <= IDLE;
                        r_mem_wrt <= 1'b0;
                        r_cool    <= 1'b1;
                        r_str_iss <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ld_gnt        = w_ld_gnt;
    assign o_st_gnt        = w_st_gnt;
    assign m_mem.mem_rd    = r_mem_rd;
    assign m_mem.mem_wrt   = r_mem_wrt;
    assign m_mem.mem_addr  = r_mem_addr;
    assign m_mem.mem_wdata = r_mem_wdata;
    assign o_vld_ld        = r_vld_ld;
    assign o_reg_wrt_ld    = r_vld_ld;
    assign o_data_ld       = r_data_ld;
    assign o_indx_ld       = r_indx_ld;
    assign o_phy_addr_ld   = r_phy_ld;
    assign o_str_iss       = r_str_iss;
    assign o_busy          = (r_state != IDLE);

`ifdef LSPS_PERF_CNT_EN
    logic [15:0] r_ld_cnt;
    logic [15:0] r_st_cnt;
    logic [15:0] r_sq_prio_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt      <= 16'd0;
            r_st_cnt      <= 16'd0;
            r_sq_prio_cnt <= 16'd0;
        end else begin
            if (r_state == LD_WAIT && m_mem.mem_vld) r_ld_cnt <= r_ld_cnt + 16'd1;
            if (r_state == ST_WAIT && m_mem.mem_vld) r_st_cnt <= r_st_cnt + 16'd1;
            if (w_st_gnt && w_st_pri) r_sq_prio_cnt <= r_sq_prio_cnt + 16'd1;
        end
    end

    assign o_ld_cnt      = r_ld_cnt;
    assign o_st_cnt      = r_st_cnt;
    assign o_sq_prio_cnt = r_sq_prio_cnt;
`endif
endmodule
